// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared constants and types for the VGA line prefetcher.
//   H_PIXELS / V_LINES describe the active display area. The framebuffer is
//   1 bit per pixel, packed WORD_W pixels per SRAM word, MSB first, so a scan
//   line is WORDS_PER_LINE consecutive words.
//   The optional underrun statistics counter is enabled by defining
//   VGA_PREFETCH_STATS_EN (see vga_line_prefetch).
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_PIXELS       = 640;
  localparam int V_LINES        = 480;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = H_PIXELS / WORD_W;
  localparam int WCNT_W         = 5;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_DONE
  } pf_state_t;

  typedef logic [WORD_W-1:0] sram_word_t;

  // Word address of the first framebuffer word of a scan line. Arithmetic is
  // deliberately 32-bit and wraps, matching the SRAM address space.
  function automatic logic [31:0] line_base(input logic [31:0] fb_base,
                                            input logic [8:0]  line_idx);
    return fb_base + (32'(line_idx) * 32'(WORDS_PER_LINE));
  endfunction

endpackage

// File: rtl/vga_line_buf.sv
// ----------------------------------------------------------------------------
// vga_line_buf
//   Ping-pong line storage: 2 buffers x WORDS_PER_LINE words x WORD_W bits.
//   One synchronous write port (used by the SRAM fetch) and one registered
//   pixel read port (used by the display side). The read port selects the
//   word by pix_x[9:5] and the bit MSB-first by pix_x[4:0].
// Ports
//   clk, rst     clock, asynchronous active-high reset (read register only;
//                the storage array itself is not reset)
//   wr_en        write strobe
//   wr_buf       buffer index written
//   wr_idx       word index within the buffer
//   wr_data      word to store
//   rd_en        pixel read qualifier (strobe and buffer validity)
//   rd_buf       buffer index read
//   rd_x         pixel column
//   pixel_out    registered pixel, 1-cycle latency
// ----------------------------------------------------------------------------
module vga_line_buf
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_buf,
  input  logic [WCNT_W-1:0] wr_idx,
  input  sram_word_t        wr_data,
  input  logic              rd_en,
  input  logic              rd_buf,
  input  logic [9:0]        rd_x,
  output logic              pixel_out
);

  sram_word_t        mem_q [2][WORDS_PER_LINE];

  logic              rd_in_range;
  logic [WCNT_W-1:0] rd_word_idx;
  sram_word_t        rd_word;
  logic              pixel_d;
  logic              pixel_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_buf][wr_idx] <= wr_data;
    end
  end

  // Columns past the active width never index the array; the word index is
  // forced to 0 and the result is masked off.
  always_comb begin
    rd_in_range = (rd_x < 10'(H_PIXELS));
    rd_word_idx = rd_in_range ? rd_x[9:5] : '0;
    rd_word     = mem_q[rd_buf][rd_word_idx];
    // ~x[4:0] == 31 - x[4:0], giving MSB-first bit order within the word.
    pixel_d     = rd_en & rd_in_range & rd_word[~rd_x[4:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_q <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;

endmodule

// File: rtl/vga_line_prefetch.sv
// ----------------------------------------------------------------------------
// vga_line_prefetch
//   Fetches one 1-bpp scan line from SRAM into the fill half of a ping-pong
//   line buffer while the display half is read by VGA_out. Each line_start
//   swaps the halves and starts fetching the requested next line.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   frame_base      word address of framebuffer line 0
//   line_start      1-cycle pulse at the start of each line's h-blank
//   next_line       line index to prefetch, sampled with line_start
//   pix_x, pix_rd   display-side pixel column and read strobe
//   pixel_out       pixel for the pix_x of the previous cycle
//   sram_rd         SRAM read request (held while sram_busy is high)
//   sram_addr       SRAM word address
//   byte_select     all lanes enabled while reading
//   sram_busy       SRAM not ready
//   sram_data_in    read data, valid on a cycle with sram_rd=1, sram_busy=0
//   fetch_done      fill buffer holds the complete requested line
//   underrun        sticky: a line_start interrupted an unfinished fetch
//   underrun_cnt    (only with VGA_PREFETCH_STATS_EN) saturating count of
//                   underrun events
// ----------------------------------------------------------------------------
module vga_line_prefetch
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame_base,
  input  logic        line_start,
  input  logic [8:0]  next_line,
  input  logic [9:0]  pix_x,
  input  logic        pix_rd,
  output logic        pixel_out,
  output logic        sram_rd,
  output logic [31:0] sram_addr,
  output logic [3:0]  byte_select,
  input  logic        sram_busy,
  input  sram_word_t  sram_data_in,
  output logic        fetch_done,
  output logic        underrun
`ifdef VGA_PREFETCH_STATS_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);

  pf_state_t         state_q, state_d;
  logic              disp_sel_q, disp_sel_d;
  logic [1:0]        buf_valid_q, buf_valid_d;
  logic [31:0]       lbase_q, lbase_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic              sram_rd_q, sram_rd_d;
  logic [31:0]       sram_addr_q, sram_addr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              underrun_q, underrun_d;

  logic              beat;
  logic              final_beat;
  logic              underrun_event;
  logic [31:0]       new_base;

  // Next-state logic. The fetch beat is evaluated first and line_start is
  // layered on top, so a final beat landing on the same edge as line_start
  // marks its buffer valid before the swap hands that buffer to the display.
  always_comb begin
    state_d        = state_q;
    disp_sel_d     = disp_sel_q;
    buf_valid_d    = buf_valid_q;
    lbase_d        = lbase_q;
    word_cnt_d     = word_cnt_q;
    sram_rd_d      = sram_rd_q;
    sram_addr_d    = sram_addr_q;
    fetch_done_d   = fetch_done_q;
    underrun_d     = underrun_q;

    beat           = (state_q == PF_FETCH) && !sram_busy;
    final_beat     = beat && (word_cnt_q == LAST_WORD);
    underrun_event = line_start && (state_q == PF_FETCH) && !final_beat;
    new_base       = line_base(frame_base, next_line);

    if (beat) begin
      word_cnt_d  = word_cnt_q + 1'b1;
      sram_addr_d = lbase_q + 32'(word_cnt_q) + 32'd1;
    end

    if (final_beat) begin
      state_d                  = PF_DONE;
      sram_rd_d                = 1'b0;
      buf_valid_d[~disp_sel_q] = 1'b1;
      fetch_done_d             = 1'b1;
    end

    if (line_start) begin
      // The old fill buffer keeps the validity computed above and becomes
      // the display buffer; the old display buffer becomes the new fill.
      disp_sel_d              = ~disp_sel_q;
      buf_valid_d[disp_sel_q] = 1'b0;
      fetch_done_d            = 1'b0;
      lbase_d                 = new_base;
      word_cnt_d              = '0;
      if (underrun_event) begin
        underrun_d = 1'b1;
      end
      // Lines beyond the active area are v-blank: leave the SRAM idle.
      if (next_line < 9'(V_LINES)) begin
        state_d     = PF_FETCH;
        sram_rd_d   = 1'b1;
        sram_addr_d = new_base;
      end else begin
        state_d     = PF_DONE;
        sram_rd_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PF_IDLE;
      disp_sel_q   <= 1'b0;
      buf_valid_q  <= 2'b00;
      lbase_q      <= '0;
      word_cnt_q   <= '0;
      sram_rd_q    <= 1'b0;
      sram_addr_q  <= '0;
      fetch_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_sel_q   <= disp_sel_d;
      buf_valid_q  <= buf_valid_d;
      lbase_q      <= lbase_d;
      word_cnt_q   <= word_cnt_d;
      sram_rd_q    <= sram_rd_d;
      sram_addr_q  <= sram_addr_d;
      fetch_done_q <= fetch_done_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Saturating event counter; holds at all-ones rather than wrapping.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_event && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  // Without statistics the sticky underrun flag is the only record.
`endif

  vga_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (beat),
    .wr_buf    (~disp_sel_q),
    .wr_idx    (word_cnt_q),
    .wr_data   (sram_data_in),
    .rd_en     (pix_rd & buf_valid_q[disp_sel_q]),
    .rd_buf    (disp_sel_q),
    .rd_x      (pix_x),
    .pixel_out (pixel_out)
  );

  assign sram_rd     = sram_rd_q;
  assign sram_addr   = sram_addr_q;
  assign byte_select = sram_rd_q ? 4'b1111 : 4'b0000;
  assign fetch_done  = fetch_done_q;
  assign underrun    = underrun_q;

endmodule
